plru_replacement: RTL

Tree pseudo-LRU replacement unit for the 4-way set-associative cache, directly downstream of `hit_detector`. It consumes the per-access `hit` / `hit_direction` result and keeps 3 PLRU bits per set. It supplies the cache controller with a victim way on a miss, latching that victim until the line fill completes. Prefers invalid ways over PLRU choice.

---
 rtl/plru_replacement_pkg.sv | 43 ++++
 rtl/plru_replacement_decode.sv | 27 ++
 rtl/plru_replacement.sv | 76 +++++++
 3 files changed

// File: rtl/plru_replacement_pkg.sv
// Shared types and helpers for the 4-way tree pseudo-LRU replacement unit.
// The tree bits are ordered {b2,b1,b0}. b0 picks the pair {0,1} or {2,3}.
// b1 picks the way inside pair {0,1}, and b2 picks the way inside pair {2,3}.
package plru_replacement_pkg;

  typedef logic [2:0] plru_bits;
  typedef logic [3:0] way_onehot;

  localparam plru_bits PLRU_RESET = 3'b000;

  // Keep only the lowest set bit. This resolves a multi-hot hit vector.
  function automatic way_onehot lowest_way(input way_onehot w);
    way_onehot r;
    r = '0;
    if (w[0])      r = 4'b0001;
    else if (w[1]) r = 4'b0010;
    else if (w[2]) r = 4'b0100;
    else if (w[3]) r = 4'b1000;
    return r;
  endfunction

  // Make the tree bits point away from the touched way.
  // An all-zero way vector leaves the bits unchanged.
  function automatic plru_bits touch(input plru_bits cur, input way_onehot w);
    plru_bits r;
    r = cur;
    if (w[0]) begin
      r[0] = 1'b1;
      r[1] = 1'b1;
    end else if (w[1]) begin
      r[0] = 1'b1;
      r[1] = 1'b0;
    end else if (w[2]) begin
      r[0] = 1'b0;
      r[2] = 1'b1;
    end else if (w[3]) begin
      r[0] = 1'b0;
      r[2] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/plru_replacement_decode.sv
// Victim decode: lowest invalid way first, otherwise follow the tree bits.
// Latency: purely combinational.
// Backpressure: none (stateless).
module plru_decode
  import plru_replacement_pkg::*;
(
  input  logic [2:0] plru,
  input  logic [3:0] valid,
  output logic [3:0] victim
);

  way_onehot pick;

  // An invalid way always wins; otherwise b0 picks the pair and b1/b2 pick within it.
  always_comb begin
    pick = 4'b0001;
    if (!valid[0])      pick = 4'b0001;
    else if (!valid[1]) pick = 4'b0010;
    else if (!valid[2]) pick = 4'b0100;
    else if (!valid[3]) pick = 4'b1000;
    else if (!plru[0])  pick = plru[1] ? 4'b0010 : 4'b0001;
    else                pick = plru[2] ? 4'b1000 : 4'b0100;
  end

  assign victim = pick;

endmodule

// File: rtl/plru_replacement.sv
// Tree PLRU per set: updates on hits and fills, and latches a victim on a miss until the fill completes.
// Latency: latched victim and miss_pending appear 1 cycle after the miss; PLRU updates are visible to decode next cycle.
// Backpressure: while miss_pending is set, further misses are ignored and the controller must stall and re-present them.
module plru_replacement
  import plru_replacement_pkg::*;
#(
  parameter int NUM_SETS    = 8,
  parameter int INDEX_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   access,
  input  logic [INDEX_WIDTH-1:0] index,
  input  logic                   hit,
  input  logic [3:0]             hit_direction,
  input  logic [3:0]             valid,
  input  logic                   fill_done,
  output logic [3:0]             victim_way,
  output logic [INDEX_WIDTH-1:0] victim_index,
  output logic                   miss_pending
);

  plru_bits  plru_q [NUM_SETS];
  way_onehot decoded_victim;
  way_onehot hit_way;
  logic      hit_upd;
  logic      fill_upd;
  logic      miss_latch;

  plru_decode u_decode (
    .plru   (plru_q[index]),
    .valid  (valid),
    .victim (decoded_victim)
  );

  assign hit_way    = lowest_way(hit_direction);
  assign hit_upd    = access && hit && (hit_direction != 4'b0000);
  assign fill_upd   = fill_done && miss_pending;
  // A fill in the same cycle as a new miss still has miss_pending high, so the miss is refused.
  assign miss_latch = access && !hit && !miss_pending;

  // Per-set tree update; a fill to a set takes priority over a hit to the same set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        plru_q[s] <= PLRU_RESET;
      end
    end else begin
      for (int s = 0; s < NUM_SETS; s++) begin
        if (fill_upd && (victim_index == INDEX_WIDTH'(s))) begin
          plru_q[s] <= touch(plru_q[s], victim_way);
        end else if (hit_upd && (index == INDEX_WIDTH'(s))) begin
          plru_q[s] <= touch(plru_q[s], hit_way);
        end
      end
    end
  end

  // Latch the victim on an accepted miss and hold it; the fill only clears the pending flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      victim_way   <= 4'b0001;
      victim_index <= '0;
      miss_pending <= 1'b0;
    end else begin
      if (miss_latch) begin
        victim_way   <= decoded_victim;
        victim_index <= index;
        miss_pending <= 1'b1;
      end else if (fill_upd) begin
        miss_pending <= 1'b0;
      end
    end
  end

endmodule
